// File: rtl/matmul_uart_sequencer.sv
// UART-driven job sequencer for a 3x3 matrix multiplier: collects 18 operand
// bytes after a request header, runs the multiplier, then streams back a
// response header and the nine 6-bit result elements (or an error byte).
module matmul_uart_sequencer #(
  parameter logic [7:0]  HDR_IN   = 8'hA5,
  parameter logic [7:0]  HDR_OUT  = 8'h5A,
  parameter logic [7:0]  ERR_BYTE = 8'hEE,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mm_load,
  output logic [26:0] mm_matrixA,
  output logic [26:0] mm_matrixB,
  input  logic [53:0] mm_result,
  input  logic [1:0]  mm_state,
  output logic        busy,
  output logic        err,
  output logic [7:0]  job_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_LOAD, S_WAIT, S_SEND_HDR, S_SEND_DATA, S_SEND_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  j_q, j_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  mm_prev_q;
  logic [53:0] res_q, res_d;
  logic [26:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic        mm_load_q, mm_load_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  job_count_q, job_count_d;

  // State and output registers; everything returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      j_q         <= '0;
      wait_cnt_q  <= '0;
      mm_prev_q   <= '0;
      res_q       <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      mm_load_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      j_q         <= j_d;
      wait_cnt_q  <= wait_cnt_d;
      mm_prev_q   <= mm_state;
      res_q       <= res_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      mm_load_q   <= mm_load_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      job_count_q <= job_count_d;
    end
  end

  // Next-state logic; tx_valid/tx_data are computed one cycle ahead so the
  // registered outputs present each new byte right after the prior handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    j_d         = j_q;
    wait_cnt_d  = wait_cnt_q;
    res_d       = res_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    mm_load_d   = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    err_d       = err_q;
    job_count_d = job_count_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HDR_IN) begin
          state_d = S_RECV;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_RECV: begin
        if (rx_valid) begin
          if (rx_data[7:3] != 5'd0) begin
            err_d      = 1'b1;
            state_d    = S_SEND_ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end else begin
            for (int unsigned k = 0; k < 9; k++) begin
              if (idx_q == 5'(k))     mat_a_d[3*k +: 3] = rx_data[2:0];
              if (idx_q == 5'(k + 9)) mat_b_d[3*k +: 3] = rx_data[2:0];
            end
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'd17) state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (mm_state == 2'd0) begin
          mm_load_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mm_prev_q == 2'd3 && mm_state == 2'd0) begin
          res_d      = mm_result;
          state_d    = S_SEND_HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_OUT;
        end else if (wait_cnt_q == TIMEOUT - 1) begin
          err_d      = 1'b1;
          state_d    = S_SEND_ERR;
          tx_valid_d = 1'b1;
          tx_data_d  = ERR_BYTE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      S_SEND_HDR: begin
        if (tx_ready) begin
          state_d   = S_SEND_DATA;
          j_d       = '0;
          tx_data_d = {2'b00, res_q[5:0]};
        end
      end
      S_SEND_DATA: begin
        if (tx_ready) begin
          if (j_q == 4'd8) begin
            state_d     = S_IDLE;
            tx_valid_d  = 1'b0;
            job_count_d = job_count_q + 8'd1;
          end else begin
            j_d = j_q + 4'd1;
            for (int unsigned k = 1; k < 9; k++) begin
              if (j_q + 4'd1 == 4'(k)) tx_data_d = {2'b00, res_q[6*k +: 6]};
            end
          end
        end
      end
      S_SEND_ERR: begin
        if (tx_ready) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign mm_load    = mm_load_q;
  assign mm_matrixA = mat_a_q;
  assign mm_matrixB = mat_b_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign job_count  = job_count_q;

endmodule

// File: tb/tb_matmul_uart_sequencer.sv
// Directed bench for matmul_uart_sequencer with a behavioural 3x3 multiplier.
module tb_matmul_uart_sequencer;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        mm_load;
  logic [26:0] mm_matrixA, mm_matrixB;
  logic [53:0] mm_result;
  logic [1:0]  mm_state;
  logic        busy, err;
  logic [7:0]  job_count;

  int passed = 0;
  int total  = 0;

  matmul_uart_sequencer #(
    .HDR_IN(8'hA5), .HDR_OUT(8'h5A), .ERR_BYTE(8'hEE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mm_load(mm_load), .mm_matrixA(mm_matrixA), .mm_matrixB(mm_matrixB),
    .mm_result(mm_result), .mm_state(mm_state), .busy(busy), .err(err),
    .job_count(job_count)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: idle -> load -> compute (3 cycles) -> store -> idle.
  // With stuck set it never leaves the load state.
  logic        stuck = 1'b0;
  logic [1:0]  ms;
  logic [53:0] mres;
  logic [26:0] ca, cb;
  int          mcnt;

  function automatic logic [53:0] mmul(input logic [26:0] a, input logic [26:0] b);
    logic [53:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(a[3*(i*3+k) +: 3]) * int'(b[3*(k*3+j) +: 3]);
        r[6*(i*3+j) +: 6] = s[5:0];
      end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms <= 2'd0; mres <= '0; ca <= '0; cb <= '0; mcnt <= 0;
    end else begin
      case (ms)
        2'd0: if (mm_load) begin ms <= 2'd1; ca <= mm_matrixA; cb <= mm_matrixB; end
        2'd1: if (!stuck) begin ms <= 2'd2; mcnt <= 0; end
        2'd2: begin
          mcnt <= mcnt + 1;
          if (mcnt == 2) begin ms <= 2'd3; mres <= mmul(ca, cb); end
        end
        default: ms <= 2'd0;
      endcase
    end
  end
  assign mm_state  = ms;
  assign mm_result = mres;

  // Monitor: record accepted tx bytes, load pulses and timing.
  logic [7:0] txq[$];
  int cyc = 0;
  int load_cnt = 0;
  int load_cyc = 0;
  int first_tx = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (mm_load) begin load_cnt++; load_cyc = cyc; end
      if (tx_valid && first_tx < 0) first_tx = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic send_job(input logic [7:0] v [18]);
    send_byte(8'hA5);
    for (int k = 0; k < 18; k++) send_byte(v[k]);
  endtask

  task automatic wait_bytes(input int n);
    int c;
    c = 0;
    while (txq.size() < n && c < 400) begin @(posedge clk); #1; c++; end
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    txq.delete(); load_cnt = 0; first_tx = -1;
  endtask

  task automatic test_reset();
    total++; if (tx_valid !== 1'b0)  $display("FAIL reset_tx_valid got %b want 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00)  $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
    total++; if (mm_load !== 1'b0)   $display("FAIL reset_mm_load got %b want 0", mm_load); else passed++;
    total++; if (busy !== 1'b0)      $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (err !== 1'b0)       $display("FAIL reset_err got %b want 0", err); else passed++;
    total++; if (job_count !== 8'd0) $display("FAIL reset_job_count got %0d want 0", job_count); else passed++;
    total++; if (mm_matrixA !== 27'd0) $display("FAIL reset_matA got %h want 0", mm_matrixA); else passed++;
    total++; if (mm_matrixB !== 27'd0) $display("FAIL reset_matB got %h want 0", mm_matrixB); else passed++;
  endtask

  task automatic test_identity();
    logic [7:0] v [18] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                           8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
    logic [7:0] got;
    clear_mon();
    send_job(v);
    wait_bytes(10);
    total++; if (txq.size() !== 10) $display("FAIL ident_count got %0d want 10", txq.size()); else passed++;
    for (int k = 0; k < 10; k++) begin
      got = (k < txq.size()) ? txq[k] : 8'hxx;
      total++;
      if (got !== ((k == 0) ? 8'h5A : 8'h05)) $display("FAIL ident_byte%0d got %h want %h", k, got, (k == 0) ? 8'h5A : 8'h05);
      else passed++;
    end
    total++; if (job_count !== 8'd1) $display("FAIL ident_job_count got %0d want 1", job_count); else passed++;
    total++; if (load_cnt !== 1)     $display("FAIL ident_load_pulses got %0d want 1", load_cnt); else passed++;
    total++; if (busy !== 1'b0)      $display("FAIL ident_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_all_sevens();
    logic [7:0] v [18];
    logic [7:0] got;
    for (int k = 0; k < 18; k++) v[k] = 8'h07;
    clear_mon();
    send_job(v);
    wait_bytes(10);
    total++; if (txq.size() !== 10) $display("FAIL sevens_count got %0d want 10", txq.size()); else passed++;
    for (int k = 0; k < 10; k++) begin
      got = (k < txq.size()) ? txq[k] : 8'hxx;
      total++;
      if (got !== ((k == 0) ? 8'h5A : 8'h13)) $display("FAIL sevens_byte%0d got %h want %h", k, got, (k == 0) ? 8'h5A : 8'h13);
      else passed++;
    end
    total++; if (err !== 1'b0)       $display("FAIL sevens_err got %b want 0", err); else passed++;
    total++; if (job_count !== 8'd2) $display("FAIL sevens_job_count got %0d want 2", job_count); else passed++;
  endtask

  task automatic test_bad_byte();
    logic [7:0] z [18];
    logic [7:0] got;
    for (int k = 0; k < 18; k++) z[k] = 8'h00;
    clear_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h08);
    wait_bytes(1);
    got = (txq.size() > 0) ? txq[0] : 8'hxx;
    total++; if (txq.size() !== 1)   $display("FAIL bad_count got %0d want 1", txq.size()); else passed++;
    total++; if (got !== 8'hEE)      $display("FAIL bad_byte got %h want EE", got); else passed++;
    total++; if (err !== 1'b1)       $display("FAIL bad_err got %b want 1", err); else passed++;
    total++; if (load_cnt !== 0)     $display("FAIL bad_load_pulses got %0d want 0", load_cnt); else passed++;
    total++; if (job_count !== 8'd2) $display("FAIL bad_job_count got %0d want 2", job_count); else passed++;
    // A fresh header clears the sticky error; finish the job with zero operands.
    clear_mon();
    send_byte(8'hA5);
    total++; if (err !== 1'b0)  $display("FAIL bad_err_cleared got %b want 0", err); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL bad_busy_recv got %b want 1", busy); else passed++;
    for (int k = 0; k < 18; k++) send_byte(z[k]);
    wait_bytes(10);
    total++; if (txq.size() !== 10) $display("FAIL zero_count got %0d want 10", txq.size()); else passed++;
    for (int k = 0; k < 10; k++) begin
      got = (k < txq.size()) ? txq[k] : 8'hxx;
      total++;
      if (got !== ((k == 0) ? 8'h5A : 8'h00)) $display("FAIL zero_byte%0d got %h want %h", k, got, (k == 0) ? 8'h5A : 8'h00);
      else passed++;
    end
    total++; if (job_count !== 8'd3) $display("FAIL zero_job_count got %0d want 3", job_count); else passed++;
  endtask

  task automatic test_timeout();
    logic [7:0] v [18];
    logic [7:0] got;
    for (int k = 0; k < 18; k++) v[k] = 8'h03;
    stuck = 1'b1;
    clear_mon();
    send_job(v);
    wait_bytes(1);
    got = (txq.size() > 0) ? txq[0] : 8'hxx;
    total++; if (txq.size() !== 1)   $display("FAIL to_count got %0d want 1", txq.size()); else passed++;
    total++; if (got !== 8'hEE)      $display("FAIL to_byte got %h want EE", got); else passed++;
    total++; if (first_tx - load_cyc !== TO) $display("FAIL to_latency got %0d want %0d", first_tx - load_cyc, TO); else passed++;
    total++; if (err !== 1'b1)       $display("FAIL to_err got %b want 1", err); else passed++;
    total++; if (job_count !== 8'd3) $display("FAIL to_job_count got %0d want 3", job_count); else passed++;
    total++; if (busy !== 1'b0)      $display("FAIL to_busy got %b want 0", busy); else passed++;
    stuck = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_backpressure();
    // Identity times B returns B: elements 1..7,0,1.
    logic [7:0] v [18] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01};
    logic [7:0] exp [10] = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01};
    logic [7:0] got;
    int c;
    clear_mon();
    send_job(v);
    c = 0;
    while (txq.size() < 4 && c < 200) begin @(posedge clk); #1; c++; end
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h04)
        $display("FAIL bp_hold%0d got valid=%b data=%h want valid=1 data=04", k, tx_valid, tx_data);
      else passed++;
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_bytes(10);
    total++; if (txq.size() !== 10) $display("FAIL bp_count got %0d want 10", txq.size()); else passed++;
    for (int k = 0; k < 10; k++) begin
      got = (k < txq.size()) ? txq[k] : 8'hxx;
      total++;
      if (got !== exp[k]) $display("FAIL bp_byte%0d got %h want %h", k, got, exp[k]);
      else passed++;
    end
    total++; if (job_count !== 8'd4) $display("FAIL bp_job_count got %0d want 4", job_count); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v [18];
    logic [7:0] got;
    for (int k = 0; k < 18; k++) v[k] = 8'h07;
    clear_mon();
    send_byte(8'hA5);
    for (int k = 0; k < 10; k++) send_byte(8'h07);
    #3 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || mm_load !== 1'b0)
      $display("FAIL mid_rst_ctl got busy=%b txv=%b txd=%h load=%b want all 0", busy, tx_valid, tx_data, mm_load);
    else passed++;
    total++; if (mm_matrixA !== 27'd0 || mm_matrixB !== 27'd0)
      $display("FAIL mid_rst_mats got A=%h B=%h want 0", mm_matrixA, mm_matrixB);
    else passed++;
    total++; if (err !== 1'b0 || job_count !== 8'd0)
      $display("FAIL mid_rst_status got err=%b jobs=%0d want 0/0", err, job_count);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    send_byte(8'h07);
    repeat (4) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b0 || txq.size() !== 0)
      $display("FAIL mid_no_header got busy=%b bytes=%0d want 0/0", busy, txq.size());
    else passed++;
    send_job(v);
    wait_bytes(10);
    total++; if (txq.size() !== 10) $display("FAIL mid_count got %0d want 10", txq.size()); else passed++;
    for (int k = 0; k < 10; k++) begin
      got = (k < txq.size()) ? txq[k] : 8'hxx;
      total++;
      if (got !== ((k == 0) ? 8'h5A : 8'h13)) $display("FAIL mid_byte%0d got %h want %h", k, got, (k == 0) ? 8'h5A : 8'h13);
      else passed++;
    end
    total++; if (job_count !== 8'd1) $display("FAIL mid_job_count got %0d want 1", job_count); else passed++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_identity();
    test_all_sevens();
    test_bad_byte();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
